// File: rtl/arithmetic_unit.sv
// 16-bit unsigned add/sub/mul/div unit. Add, sub, mul and divide-by-zero finish in one cycle.
// Divide uses a 16-step restoring shift/subtract with registered result and flag.
module arithmetic_unit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic [PW-1:0]    prod;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   trial_sub;
  logic             q_bit;
  logic [WIDTH-1:0] quo_next;

  always_comb begin
    sum       = {1'b0, ina} + {1'b0, inb};
    diff      = ina - inb;
    prod      = PW'(ina) * PW'(inb);
    // Partial remainder stays below the divisor, so the 17-bit difference sign is the borrow
    trial     = {rem_q, quo_q[WIDTH-1]};
    trial_sub = trial - {1'b0, dvs_q};
    q_bit     = ~trial_sub[WIDTH];
    quo_next  = {quo_q[WIDTH-2:0], q_bit};
  end

  // Next-state: divider iteration has priority; requests are only taken while idle
  always_comb begin
    busy_d      = busy_q;
    out_valid_d = 1'b0;
    out_d       = out_q;
    ovf_d       = ovf_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;

    if (busy_q) begin
      quo_d = quo_next;
      rem_d = q_bit ? trial_sub[WIDTH-1:0] : trial[WIDTH-1:0];
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST_STEP) begin
        busy_d      = 1'b0;
        out_d       = quo_next;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
      end
    end else if (in_valid) begin
      case (op_e'(sel))
        OP_ADD: begin
          out_d       = sum[WIDTH-1:0];
          ovf_d       = sum[WIDTH];
          out_valid_d = 1'b1;
        end
        OP_SUB: begin
          out_d       = diff;
          ovf_d       = (ina < inb);
          out_valid_d = 1'b1;
        end
        OP_MUL: begin
          out_d       = prod[WIDTH-1:0];
          ovf_d       = |prod[PW-1:WIDTH];
          out_valid_d = 1'b1;
        end
        default: begin
          if (inb == '0) begin
            out_d       = '1;
            ovf_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            busy_d = 1'b1;
            quo_d  = ina;
            dvs_d  = inb;
            rem_d  = '0;
            cnt_d  = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      ovf_q       <= 1'b0;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_arithmetic_unit.sv
// Scoreboard bench for arithmetic_unit: driver models acceptance and pushes expected
// results with their due cycle; a negedge monitor pops and compares.
module tb_arithmetic_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] ina;
  logic [15:0] inb;
  logic [1:0]  sel;
  logic        busy;
  logic        out_valid;
  logic [15:0] out;
  logic        overflow;

  arithmetic_unit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .ina      (ina),
    .inb      (inb),
    .sel      (sel),
    .busy     (busy),
    .out_valid(out_valid),
    .out      (out),
    .overflow (overflow)
  );

  typedef struct {
    int unsigned res;
    bit          ovf;
    int          due;
    int unsigned op;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          busy_until = 0;
  int          last_rst_edge = -1;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned held_out = 0;
  bit          held_ovf = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    ina = '0;
    inb = '0;
    sel = '0;
  end

  // Reference model: plain integer arithmetic on the unsigned operands
  function automatic exp_t model(int unsigned a, int unsigned b, int unsigned op, int edge_n);
    exp_t e;
    longint unsigned p;
    e.op  = op;
    e.due = edge_n;
    case (op)
      0: begin e.res = (a + b) % 65536; e.ovf = (a + b) > 65535; end
      1: begin e.res = (a + 65536 - b) % 65536; e.ovf = (a < b); end
      2: begin p = longint'(a) * longint'(b); e.res = int'(p % 65536); e.ovf = (p > 65535); end
      default: begin
        if (b == 0) begin e.res = 65535; e.ovf = 1'b1; end
        else begin e.res = a / b; e.ovf = 1'b0; e.due = edge_n + 16; end
      end
    endcase
    return e;
  endfunction

  task automatic drive(bit v, int unsigned a, int unsigned b, int unsigned op, bit r);
    exp_t e;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    ina      = 16'(a);
    inb      = 16'(b);
    sel      = 2'(op);
    @(posedge clk);
    cyc = cyc + 1;
    if (r) begin
      sb.delete();
      busy_until    = 0;
      last_rst_edge = cyc;
    end else if (v && (cyc - 1 >= busy_until)) begin
      e = model(a, b, op, cyc);
      if (op == 3 && b != 0) busy_until = cyc + 16;
      sb.push_back(e);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0);
  endtask

  // Monitor: compare every cycle against the scoreboard head and the held result
  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0) begin
      vectors++;
      if (busy !== (cyc < busy_until)) begin
        miscompares++;
        $display("FAIL busy cyc=%0d got=%0b exp=%0b", cyc, busy, (cyc < busy_until));
      end
      if (last_rst_edge == cyc) begin
        vectors++;
        if (out !== 16'h0 || overflow !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL reset cyc=%0d got out=%h ovf=%b vld=%b busy=%b exp all zero",
                   cyc, out, overflow, out_valid, busy);
        end
        held_out = 0;
        held_ovf = 1'b0;
      end else if (out_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_valid cyc=%0d got out=%h exp no result", cyc, out);
        end else begin
          e = sb.pop_front();
          if (e.due != cyc || out !== 16'(e.res) || overflow !== e.ovf) begin
            miscompares++;
            $display("FAIL result op=%0d cyc=%0d got out=%h ovf=%b exp out=%h ovf=%b due=%0d",
                     e.op, cyc, out, overflow, 16'(e.res), e.ovf, e.due);
          end
          held_out = e.res;
          held_ovf = e.ovf;
        end
      end else begin
        vectors++;
        if (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          miscompares++;
          $display("FAIL missing_result op=%0d cyc=%0d got no out_valid exp out=%h",
                   e.op, cyc, 16'(e.res));
        end
        if (out !== 16'(held_out) || overflow !== held_ovf) begin
          miscompares++;
          $display("FAIL hold cyc=%0d got out=%h ovf=%b exp out=%h ovf=%b",
                   cyc, out, overflow, 16'(held_out), held_ovf);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 0, 0, 0, 1'b1);
    idle(1);
    // Directed cases
    drive(1'b1, 16'hFFF0, 16'h0020, 0, 1'b0);
    drive(1'b1, 100, 200, 0, 1'b0);
    drive(1'b1, 5, 7, 1, 1'b0);
    drive(1'b1, 7, 5, 1, 1'b0);
    drive(1'b1, 16'h0100, 16'h0100, 2, 1'b0);
    drive(1'b1, 300, 200, 2, 1'b0);
    drive(1'b1, 1234, 0, 3, 1'b0);
    drive(1'b1, 50000, 255, 3, 1'b0);
    // New operands while dividing must be dropped
    for (int i = 0; i < 15; i++) drive(1'b1, 16'h1111 + i, 16'h2222, 0, 1'b0);
    drive(1'b1, 9, 9, 2, 1'b0);
    idle(3);
    drive(1'b1, 65535, 1, 3, 1'b0);
    idle(17);
    drive(1'b1, 65535, 65535, 3, 1'b0);
    idle(17);
    // Reset mid-divide aborts with no result
    drive(1'b1, 40000, 3, 3, 1'b0);
    idle(6);
    drive(1'b1, 1, 1, 0, 1'b1);
    idle(20);
    // Random sweep
    for (int i = 0; i < 600; i++) begin
      int unsigned a, b, op;
      a  = $urandom_range(65535);
      b  = ($urandom_range(3) == 0) ? $urandom_range(65535) : ($urandom % 256);
      op = $urandom_range(3);
      drive(($urandom_range(3) != 0), a, b, op, 1'b0);
    end
    idle(20);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending exp 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
